// File: rtl/xcorr_pkg.sv
// xcorr_pkg
//   Shared definitions for the 1-bit cross-correlation lag scanner:
//   the scan FSM state encoding and width helpers for the score (SW)
//   and lag (LW) buses.
package xcorr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Score width: must represent 0..ndata inclusive.
  function automatic int sw_of(input int ndata);
    return $clog2(ndata) + 1;
  endfunction

  // Lag width: indexes 0..nlag-1.
  function automatic int lw_of(input int nlag);
    return $clog2(nlag);
  endfunction

endpackage

// File: rtl/bintree.sv
// bintree
//   Combinational population count built as a balanced binary adder tree.
//   Each level halves the vector and widens the partial sum by one bit,
//   so the root is exactly $clog2(N)+1 bits wide.
// Ports:
//   bits  in  N   vector to count
//   sum   out OW  number of ones in bits
module bintree #(
  parameter int N = 128,
  localparam int OW = $clog2(N) + 1
) (
  input  logic [N-1:0]  bits,
  output logic [OW-1:0] sum
);

  generate
    if (N == 1) begin : g_leaf
      assign sum = bits;
    end else begin : g_node
      logic [OW-2:0] lo_sum;
      logic [OW-2:0] hi_sum;

      bintree #(.N(N/2)) u_lo (
        .bits (bits[N/2-1:0]),
        .sum  (lo_sum)
      );

      bintree #(.N(N/2)) u_hi (
        .bits (bits[N-1:N/2]),
        .sum  (hi_sum)
      );

      assign sum = {1'b0, lo_sum} + {1'b0, hi_sum};
    end
  endgenerate

endmodule

// File: rtl/xcorr_sched.sv
// xcorr_sched
//   Lag-search sequencer for 1-bit cross-correlation. On an accepted start
//   it captures a reference window (din_a) and a lagged stream (din_b), then
//   steps the lag one position per clock. Each lag's agreement count
//   (popcount of the XNOR) is registered once and compared against the
//   running best; the strict compare makes the earliest lag win ties.
//   Latency from start acceptance to done is NLAG+1 cycles.
//
// Optional feature (macro XCORR_THRESH_EN):
//   adds min_score input and peak_ok output; peak_ok = (final best_score
//   >= min_score), registered with done and cleared on the next accept.
//
// Ports:
//   clk         in   1              clock, rising edge
//   rst_n       in   1              asynchronous active-low reset
//   start       in   1              scan request, sampled only in IDLE
//   din_a       in   NDATA          reference window
//   din_b       in   NDATA+NLAG-1   lagged stream
//   busy        out  1              high while scanning / draining
//   done        out  1              one-cycle pulse, results final
//   best_lag    out  LW             lag with maximum score
//   best_score  out  SW             maximum agreement count
//   min_score   in   SW             (XCORR_THRESH_EN) peak threshold
//   peak_ok     out  1              (XCORR_THRESH_EN) best >= threshold
module xcorr_sched
  import xcorr_pkg::*;
#(
  parameter int NDATA = 128,
  parameter int NLAG  = 32,
  localparam int SW = sw_of(NDATA),
  localparam int LW = lw_of(NLAG)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NDATA-1:0]      din_a,
  input  logic [NDATA+NLAG-2:0] din_b,
  output logic                  busy,
  output logic                  done,
  output logic [LW-1:0]         best_lag,
  output logic [SW-1:0]         best_score
`ifdef XCORR_THRESH_EN
  ,
  input  logic [SW-1:0]         min_score,
  output logic                  peak_ok
`endif
);

  localparam logic [LW-1:0] LAST_LAG = LW'(NLAG - 1);

  state_t                  state;
  logic [LW-1:0]           lag;
  logic [NDATA-1:0]        a_q;
  logic [NDATA+NLAG-2:0]   b_q;
  logic [SW-1:0]           score_q;
  logic [LW-1:0]           lag_q;
  logic                    valid_q;

  logic [NDATA-1:0]        agree;
  logic [SW-1:0]           score;
  logic                    upd;
  logic [SW-1:0]           final_score;

  // Window mux: select the NDATA-bit slice of the lagged stream for this lag.
  assign agree = ~(a_q ^ b_q[lag +: NDATA]);

  bintree #(.N(NDATA)) u_popcount (
    .bits (agree),
    .sum  (score)
  );

  // Strict greater-than keeps the earliest lag on ties.
  always_comb begin
    upd         = valid_q && (score_q > best_score);
    final_score = upd ? score_q : best_score;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lag        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      score_q    <= '0;
      lag_q      <= '0;
      valid_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      best_lag   <= '0;
      best_score <= '0;
`ifdef XCORR_THRESH_EN
      peak_ok    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      // Compare stage runs every cycle; valid_q gates it to real scores.
      if (upd) begin
        best_score <= score_q;
        best_lag   <= lag_q;
      end

      case (state)
        IDLE: begin
          valid_q <= 1'b0;
          if (start) begin
            a_q        <= din_a;
            b_q        <= din_b;
            best_score <= '0;
            best_lag   <= '0;
            lag        <= '0;
            busy       <= 1'b1;
            state      <= SCAN;
`ifdef XCORR_THRESH_EN
            peak_ok    <= 1'b0;
`endif
          end
        end

        SCAN: begin
          score_q <= score;
          lag_q   <= lag;
          valid_q <= 1'b1;
          // Lag saturates at the last position; DRAIN flushes its score.
          if (lag == LAST_LAG) begin
            state <= DRAIN;
          end else begin
            lag <= lag + 1'b1;
          end
        end

        DRAIN: begin
          valid_q <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= IDLE;
`ifdef XCORR_THRESH_EN
          // Use the post-compare best so the last lag is included.
          peak_ok <= (final_score >= min_score);
`endif
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xcorr_sched.sv
// tb_xcorr_sched
//   Directed self-checking bench for xcorr_sched (NDATA=128, NLAG=32).
//   Covers reset state, exact match, ties, no agreement, start during a
//   scan, start held through done, mid-scan reset, and model-checked
//   pseudo-random windows. Threshold checks compile when XCORR_THRESH_EN
//   is defined.
module tb_xcorr_sched;

  localparam int NDATA = 128;
  localparam int NLAG  = 32;
  localparam int SW    = 8;
  localparam int LW    = 5;
  localparam int NB    = NDATA + NLAG - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [NDATA-1:0] din_a = '0;
  logic [NB-1:0]    din_b = '0;
  logic             busy;
  logic             done;
  logic [LW-1:0]    best_lag;
  logic [SW-1:0]    best_score;
`ifdef XCORR_THRESH_EN
  logic [SW-1:0]    min_score = '0;
  logic             peak_ok;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  xcorr_sched #(.NDATA(NDATA), .NLAG(NLAG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .din_a      (din_a),
    .din_b      (din_b),
    .busy       (busy),
    .done       (done),
    .best_lag   (best_lag),
    .best_score (best_score)
`ifdef XCORR_THRESH_EN
    ,
    .min_score  (min_score),
    .peak_ok    (peak_ok)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("[TB] check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference model: direct per-lag agreement count, strict max.
  task automatic model(input logic [NDATA-1:0] a, input logic [NB-1:0] b,
                       output int bl, output int bs);
    int s;
    bl = 0;
    bs = 0;
    for (int k = 0; k < NLAG; k++) begin
      s = 0;
      for (int j = 0; j < NDATA; j++) begin
        if (a[j] == b[k+j]) s++;
      end
      if (s > bs) begin
        bs = s;
        bl = k;
      end
    end
  endtask

  // Present a start at the next negedge; returns #1 after the accept edge.
  task automatic launch(input logic [NDATA-1:0] a, input logic [NB-1:0] b);
    @(negedge clk);
    din_a = a;
    din_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count rising edges until done is seen; bounded.
  task automatic wait_done(output int cyc, output int ok);
    cyc = 0;
    ok  = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic scan_and_check(input string tag, input logic [NDATA-1:0] a,
                                input logic [NB-1:0] b, input int exp_lag,
                                input int exp_score);
    int cyc, ok;
    launch(a, b);
    check({tag, "_busy"}, 32'(busy), 1);
    wait_done(cyc, ok);
    check({tag, "_done_seen"}, 32'(ok), 1);
    check({tag, "_latency"}, 32'(cyc), NLAG + 1);
    check({tag, "_lag"}, 32'(best_lag), 32'(exp_lag));
    check({tag, "_score"}, 32'(best_score), 32'(exp_score));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_busy_low"}, 32'(busy), 0);
    check({tag, "_lag_hold"}, 32'(best_lag), 32'(exp_lag));
  endtask

  initial begin
    logic [NDATA-1:0] ex_a, tie_a, rnd_a;
    logic [NB-1:0]    ex_b, tie_b, rnd_b;
    logic [6:0]       pat;
    int cyc, ok, n, el, es;

    // Exact match at lag 5, surrounding bits inverted.
    ex_a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    ex_b = '0;
    ex_b[4:0]     = ~ex_a[4:0];
    ex_b[132:5]   = ex_a;
    ex_b[158:133] = ~ex_a[127:102];

    // Period-7 stream: window matches at lags 3, 10, 17, ... -> lag 3 wins.
    pat = 7'b0010111;
    for (int i = 0; i < NB; i++) tie_b[i] = pat[i % 7];
    for (int j = 0; j < NDATA; j++) tie_a[j] = tie_b[j + 3];

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_lag", 32'(best_lag), 0);
    check("reset_score", 32'(best_score), 0);
    rst_n = 1'b1;

    scan_and_check("exact", ex_a, ex_b, 5, 128);
    scan_and_check("tie", tie_a, tie_b, 3, 128);
    scan_and_check("noagree", '0, '1, 0, 0);

    // Start pulsed mid-scan (ignored), then held through done.
    launch(ex_a, ex_b);
    repeat (9) @(posedge clk);
    #1;
    din_a = tie_a;
    din_b = tie_b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("midstart_busy", 32'(busy), 1);
    repeat (15) @(posedge clk);
    #1;
    start = 1'b1;
    wait_done(cyc, ok);
    check("held_done_seen", 32'(ok), 1);
    check("held_lag", 32'(best_lag), 5);
    check("held_score", 32'(best_score), 128);
    @(posedge clk);
    #1;
    check("held_reaccept_busy", 32'(busy), 1);
    check("held_reaccept_done", 32'(done), 0);
    check("held_reaccept_clear", 32'(best_score), 0);
    start = 1'b0;
    wait_done(cyc, ok);
    check("second_done_seen", 32'(ok), 1);
    check("second_latency", 32'(cyc), NLAG + 1);
    check("second_lag", 32'(best_lag), 3);
    check("second_score", 32'(best_score), 128);

    // Reset asserted at lag 12.
    launch(ex_a, ex_b);
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_lag", 32'(best_lag), 0);
    check("midrst_score", 32'(best_score), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    check("midrst_no_done", 32'(n), 0);
    scan_and_check("after_rst", ex_a, ex_b, 5, 128);

    // Pseudo-random windows against the reference model.
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NDATA; i++) rnd_a[i] = 1'($urandom_range(0, 1));
      for (int i = 0; i < NB; i++)    rnd_b[i] = 1'($urandom_range(0, 1));
      model(rnd_a, rnd_b, el, es);
      scan_and_check($sformatf("rand%0d", t), rnd_a, rnd_b, el, es);
    end

`ifdef XCORR_THRESH_EN
    // Best of 100 at lag 0: 100 agreeing zeros, then ones.
    rnd_a = '0;
    rnd_b = '1;
    rnd_b[99:0] = '0;
    min_score = 8'd101;
    scan_and_check("thr101", rnd_a, rnd_b, 0, 100);
    check("thr101_peak", 32'(peak_ok), 0);
    min_score = 8'd100;
    scan_and_check("thr100", rnd_a, rnd_b, 0, 100);
    check("thr100_peak", 32'(peak_ok), 1);
    launch(rnd_a, rnd_b);
    check("thr_clear_on_start", 32'(peak_ok), 0);
    wait_done(cyc, ok);
    check("thr_final_done", 32'(ok), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/xcorr_sched.md
# xcorr_sched

Sequencer for 1-bit cross-correlation lag search in the sound-source-localization datapath. It captures one reference bit window and one lagged bit window, then steps the lag one position per clock. At each lag it feeds the XNOR of the two windows to a popcount tree and keeps the lag with the highest agreement count. It sits between the microphone sign-bit buffers and the direction-estimation logic, and it owns the popcount resource for the whole scan.

## Interface
- `NDATA`, 128: correlation window length in bits; power of two, ≥4.
- `NLAG`, 32: number of lags scanned (0..NLAG-1); power of two, ≥2.
- Derived: `SW = $clog2(NDATA)+1` (score width), `LW = $clog2(NLAG)` (lag width).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  scan request; sampled only in IDLE.
- `din_a`  in  NDATA  reference window; captured on accepted start.
- `din_b`  in  NDATA+NLAG-1  lagged stream; captured on accepted start.
- `busy`  out  1  high in SCAN and DRAIN.
- `done`  out  1  one-cycle pulse when results are final.
- `best_lag`  out  LW  lag of maximum score.
- `best_score`  out  SW  maximum agreement count, 0..NDATA.
- `min_score`  in  SW  present only with `XCORR_THRESH_EN`.
- `peak_ok`  out  1  present only with `XCORR_THRESH_EN`.

## Operation
- Score for lag k = popcount(`din_a` XNOR `din_b[k+NDATA-1:k]`), using the captured copies.
- FSM states:
  - IDLE: if `start` is high, capture the inputs, clear `best_*` to 0, set `lag` to 0, and go to SCAN.
  - SCAN: present lag `lag` to the popcount. Register the score and lag into the pipeline stage with its valid bit set. Increment `lag`. When `lag == NLAG-1`, go to DRAIN.
  - DRAIN: the last pipelined score is compared. Go to IDLE with `done` set.
- Compare stage: when the pipeline valid bit is set and `score_q > best_score`, update both `best_score` and `best_lag`.
  - The comparison is strict, so on ties the earliest lag wins.
  - If every score is 0, the result is `best_lag`=0 and `best_score`=0.
- `start` while busy: ignored, with no queuing. The captured data does not change mid-scan.
- `start` held high across `done`: a new scan begins in the cycle after `done`, because the FSM is back in IDLE.
- `best_lag` and `best_score` hold their values from `done` until the next accepted start.
- The lag counter never wraps during a scan. It stops at NLAG-1.

## Timing
- Reset (asynchronous assert, any state including mid-scan):
  - state=IDLE; `busy`, `done`, `best_lag`, `best_score`, `lag`, and pipeline valid all 0.
  - `peak_ok`=0 when `XCORR_THRESH_EN` is defined.
  - The scan is abandoned and no `done` is produced.
- Start accepted at edge E0. `busy` is high from E0 through edge E0+NLAG+1.
- Score for lag k is registered at edge E0+1+k. It is compared at edge E0+2+k.
- `done` is registered high at edge E0+NLAG+1, together with the final `best_*` values. `busy` drops at that same edge.
- Latency is NLAG+1 cycles from start acceptance to `done`. The earliest next accept is edge E0+NLAG+2.
- The popcount path is combinational within one cycle. Only one register stage follows it.

## Configuration
- `XCORR_THRESH_EN` defined:
  - Adds `min_score` and `peak_ok`.
  - `peak_ok` is registered with `done` as (`best_score` ≥ `min_score`), using the final best value.
  - `peak_ok` holds until the next accepted start, which clears it.
- Not defined: neither port exists and the FSM behaviour is identical.

## Structure
- Package `xcorr_pkg`: the FSM state enum (IDLE, SCAN, DRAIN) and width helper functions for SW and LW.
- One sub-module: the existing `bintree` adder, instantiated once with `NDATA`, as the popcount. Its output width equals SW.
- The window mux (lag shift select) and the compare logic live in `xcorr_sched`.

## Test plan
- Exact match: `din_b` holds `din_a` at offset 5, with all other bits the inverse of the neighbouring pattern → `done` at start+33 cycles, `best_lag`=5, `best_score`=128.
- Tie: the window matches at lags 3 and 10 with equal score 128 → `best_lag`=3.
- No agreement: `din_a` all 0, `din_b` all 1 → `best_lag`=0, `best_score`=0, single `done` pulse.
- `start` pulsed during a scan, and held high through `done` → the second pulse is ignored; the held start launches a new scan exactly one cycle after `done`.
- `rst_n` low at lag 12 → all outputs 0 immediately, no `done`; a fresh start then completes normally.
- With `XCORR_THRESH_EN`: best 100 and `min_score`=101 → `peak_ok`=0; `min_score`=100 → `peak_ok`=1.
